// File: rtl/wallace_mul32_seq_if.sv
// ============================================================================
// wallace_mul32_seq_if : request/result handshake bundle for wallace_mul32_seq
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface wallace_mul32_seq_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_prod;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_prod, out_tag, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_prod, out_tag, busy
  );
endinterface

`default_nettype wire

// File: rtl/wallace_mul32_seq.sv
// ============================================================================
// wallace_mul32_seq : 32x32 unsigned multiply sequenced over one 16x16 Wallace tree
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module wallace16x16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] prod
);
  // Rows remaining after each 3:2 carry-save level, ending at two rows.
  localparam int LVL_ROWS [7] = '{16, 11, 8, 6, 4, 3, 2};

  logic [31:0] rows [7][16];

  always_comb begin
    for (int l = 0; l < 7; l++) begin
      for (int r = 0; r < 16; r++) begin
        rows[l][r] = 32'd0;
      end
    end
    for (int r = 0; r < 16; r++) begin
      rows[0][r] = b[r] ? ({16'd0, a} << r) : 32'd0;
    end
    // Carries are truncated at bit 31; the true product always fits in 32 bits.
    for (int l = 0; l < 6; l++) begin
      for (int k = 0; k < LVL_ROWS[l] / 3; k++) begin
        rows[l+1][2*k]   = rows[l][3*k] ^ rows[l][3*k+1] ^ rows[l][3*k+2];
        rows[l+1][2*k+1] = ((rows[l][3*k]   & rows[l][3*k+1]) |
                            (rows[l][3*k]   & rows[l][3*k+2]) |
                            (rows[l][3*k+1] & rows[l][3*k+2])) << 1;
      end
      for (int k = 0; k < LVL_ROWS[l] % 3; k++) begin
        rows[l+1][2*(LVL_ROWS[l]/3)+k] = rows[l][3*(LVL_ROWS[l]/3)+k];
      end
    end
    prod = rows[6][0] + rows[6][1];
  end
endmodule

module wallace_mul32_seq #(
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  wallace_mul32_seq_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [63:0]      acc_q, acc_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [15:0]      op_a;
  logic [15:0]      op_b;
  logic [31:0]      prod;
  logic [63:0]      addend;

  assign op_a = step_q[0] ? a_q[31:16] : a_q[15:0];
  assign op_b = step_q[1] ? b_q[31:16] : b_q[15:0];

  wallace16x16 u_tree (
    .a    (op_a),
    .b    (op_b),
    .prod (prod)
  );

  always_comb begin
    addend = 64'd0;
    case (step_q)
      2'd0:    addend = {32'd0, prod};
      2'd1,
      2'd2:    addend = {16'd0, prod, 16'd0};
      default: addend = {prod, 32'd0};
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          tag_d   = bus.in_tag;
          acc_d   = 64'd0;
          state_d = S_MUL;
          // Zero operand: run only the hi*hi step, which contributes 0, for 1-cycle latency.
          step_d  = (bus.in_a == 32'd0 || bus.in_b == 32'd0) ? 2'd3 : 2'd0;
        end
      end
      S_MUL: begin
        acc_d  = acc_q + addend;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      step_q      <= 2'd0;
      acc_q       <= 64'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      tag_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_prod  = acc_q;
  assign bus.out_tag   = tag_q;
endmodule

`default_nettype wire
